// File: rtl/i2c_bus_conditioner_if.sv
// rtl/i2c_bus_conditioner_if.sv - pad inputs and conditioned bus-event outputs of i2c_bus_conditioner
//
// Signals:
//   in_scl, in_sda      raw asynchronous pad levels (driven by the pad side)
//   out_scl, out_sda    filtered levels
//   out_scl_rise/fall   one-cycle filtered SCL edge strobes
//   out_start/out_stop  one-cycle START (incl. repeated START) / STOP strobes
//   out_bus_busy        high from START until STOP or timeout
//   out_timeout         one-cycle strobe when SCL has been held low too long while busy
// Modports: slave = the conditioner, master = pad side / consumer.
interface i2c_bus_conditioner_if;
    logic in_scl;
    logic in_sda;
    logic out_scl;
    logic out_sda;
    logic out_scl_rise;
    logic out_scl_fall;
    logic out_start;
    logic out_stop;
    logic out_bus_busy;
    logic out_timeout;

    modport slave (
        input  in_scl, in_sda,
        output out_scl, out_sda, out_scl_rise, out_scl_fall,
               out_start, out_stop, out_bus_busy, out_timeout
    );

    modport master (
        output in_scl, in_sda,
        input  out_scl, out_sda, out_scl_rise, out_scl_fall,
               out_start, out_stop, out_bus_busy, out_timeout
    );
endinterface

// File: rtl/i2c_bus_conditioner.sv
// rtl/i2c_bus_conditioner.sv - synchronize, deglitch and decode raw I2C pad levels into bus-event strobes
//
// Ports:
//   in_clk    system clock, rising edge
//   in_rst_p  synchronous reset, active-high
//   bus       i2c_bus_conditioner_if.slave (pads in, filtered levels and strobes out)
// Parameters:
//   SYNC_STAGES     synchronizer depth (>= 2)
//   FILTER_CYCLES   cycles a synchronized level must hold before it is accepted (>= 1)
//   TIMEOUT_CYCLES  busy SCL-low cycles before a timeout; 0 removes the timeout logic
module i2c_bus_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                  in_clk,
    input  logic                  in_rst_p,
    i2c_bus_conditioner_if.slave  bus
);

    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic [FW-1:0]          scl_cnt;
    logic [FW-1:0]          sda_cnt;
    logic                   scl_filt;
    logic                   sda_filt;
    logic                   scl_toggle;
    logic                   sda_toggle;
    logic                   start_evt;
    logic                   stop_evt;
    logic                   timeout_evt;
    logic [0:0]             state;
    logic                   scl_rise_q;
    logic                   scl_fall_q;
    logic                   start_q;
    logic                   stop_q;
    logic                   timeout_q;

    always_ff @(posedge in_clk) begin
        if (in_rst_p) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.in_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.in_sda};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // The filtered level flips on the cycle the counter would reach FILTER_CYCLES,
    // giving a fixed SYNC_STAGES+FILTER_CYCLES pad-to-output latency.
    assign scl_toggle = (scl_s != scl_filt) && (scl_cnt == FW'(FILTER_CYCLES - 1));
    assign sda_toggle = (sda_s != sda_filt) && (sda_cnt == FW'(FILTER_CYCLES - 1));

    always_ff @(posedge in_clk) begin
        if (in_rst_p) begin
            scl_cnt  <= '0;
            scl_filt <= 1'b1;
        end else if (scl_s == scl_filt) begin
            scl_cnt  <= '0;
        end else if (scl_toggle) begin
            scl_cnt  <= '0;
            scl_filt <= ~scl_filt;
        end else begin
            scl_cnt  <= scl_cnt + 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst_p) begin
            sda_cnt  <= '0;
            sda_filt <= 1'b1;
        end else if (sda_s == sda_filt) begin
            sda_cnt  <= '0;
        end else if (sda_toggle) begin
            sda_cnt  <= '0;
            sda_filt <= ~sda_filt;
        end else begin
            sda_cnt  <= sda_cnt + 1'b1;
        end
    end

    // SDA moving while SCL also moves is ambiguous, so it never counts as START/STOP.
    assign start_evt = sda_toggle &  sda_filt & scl_filt & ~scl_toggle;
    assign stop_evt  = sda_toggle & ~sda_filt & scl_filt & ~scl_toggle;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
            logic [TW-1:0] tmo_cnt;

            assign timeout_evt = (state == ST_BUSY) && !scl_filt &&
                                 (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

            always_ff @(posedge in_clk) begin
                if (in_rst_p || state != ST_BUSY || scl_filt || timeout_evt) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign timeout_evt = 1'b0;
        end
    endgenerate

    // Busy rises together with the out_start strobe but falls only after the
    // out_stop strobe, so the STOP cycle itself is still reported as busy.
    always_ff @(posedge in_clk) begin
        if (in_rst_p) begin
            state <= ST_IDLE;
        end else if (timeout_evt) begin
            state <= ST_IDLE;
        end else if (start_evt) begin
            state <= ST_BUSY;
        end else if (stop_q) begin
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst_p) begin
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            scl_rise_q <= scl_toggle & ~scl_filt;
            scl_fall_q <= scl_toggle &  scl_filt;
            start_q    <= start_evt;
            stop_q     <= stop_evt;
            timeout_q  <= timeout_evt;
        end
    end

    assign bus.out_scl      = scl_filt;
    assign bus.out_sda      = sda_filt;
    assign bus.out_scl_rise = scl_rise_q;
    assign bus.out_scl_fall = scl_fall_q;
    assign bus.out_start    = start_q;
    assign bus.out_stop     = stop_q;
    assign bus.out_bus_busy = (state == ST_BUSY);
    assign bus.out_timeout  = timeout_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// tb/tb_i2c_bus_conditioner.sv - directed self-checking bench for i2c_bus_conditioner
module tb_i2c_bus_conditioner;

    logic in_clk;
    logic in_rst_p;

    i2c_bus_conditioner_if bus_if ();

    i2c_bus_conditioner #(
        .SYNC_STAGES    (2),
        .FILTER_CYCLES  (3),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .in_clk   (in_clk),
        .in_rst_p (in_rst_p),
        .bus      (bus_if.slave)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    int n_checks;
    int n_fail;
    int n_rise, n_fall, n_start, n_stop, n_tmo, n_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_tmo = 0; n_idle = 0;
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge in_clk);
            #1;
            n_rise  += int'(bus_if.out_scl_rise);
            n_fall  += int'(bus_if.out_scl_fall);
            n_start += int'(bus_if.out_start);
            n_stop  += int'(bus_if.out_stop);
            n_tmo   += int'(bus_if.out_timeout);
            n_idle  += int'(!bus_if.out_bus_busy);
        end
    endtask

    // which: 0 start, 1 stop, 2 scl_fall, 3 timeout
    task automatic wait_strobe(input string tag, input int which, input int limit, output int waited);
        logic hit;
        waited = 0;
        hit = 1'b0;
        while (!hit && waited < limit) begin
            cyc();
            waited++;
            case (which)
                0:       hit = bus_if.out_start;
                1:       hit = bus_if.out_stop;
                2:       hit = bus_if.out_scl_fall;
                default: hit = bus_if.out_timeout;
            endcase
        end
        if (!hit) check({tag, "_expired"}, 32'(waited), 32'(limit + 1));
    endtask

    task automatic scl_clock(input logic bit_val);
        bus_if.in_scl = 1'b0;
        cyc(6);
        bus_if.in_sda = bit_val;
        cyc(6);
        bus_if.in_scl = 1'b1;
        cyc(12);
    endtask

    function automatic logic [7:0] out_vec();
        return {bus_if.out_scl, bus_if.out_sda, bus_if.out_scl_rise, bus_if.out_scl_fall,
                bus_if.out_start, bus_if.out_stop, bus_if.out_bus_busy, bus_if.out_timeout};
    endfunction

    initial begin
        int w;
        logic [8:0] frame;
        n_checks = 0;
        n_fail   = 0;
        clear_counts();

        // Reset with pads low
        in_rst_p = 1'b1;
        bus_if.in_scl = 1'b0;
        bus_if.in_sda = 1'b0;
        cyc();
        check("reset_outputs_1", 32'(out_vec()), 32'h0000_00C0);
        cyc();
        check("reset_outputs_2", 32'(out_vec()), 32'h0000_00C0);
        in_rst_p = 1'b0;
        clear_counts();
        cyc(4);
        check("reset_rel_scl_hold", 32'(bus_if.out_scl), 32'd1);
        cyc();
        check("reset_rel_scl_fall_lat5", 32'(bus_if.out_scl), 32'd0);
        check("reset_rel_sda_fall_lat5", 32'(bus_if.out_sda), 32'd0);
        check("reset_rel_fall_strobe", 32'(bus_if.out_scl_fall), 32'd1);
        cyc();
        check("reset_rel_fall_one_cycle", 32'(bus_if.out_scl_fall), 32'd0);
        check("reset_rel_no_start", 32'(n_start), 32'd0);

        // Idle bus
        bus_if.in_scl = 1'b1;
        bus_if.in_sda = 1'b1;
        cyc(10);
        check("idle_no_stop", 32'(n_stop), 32'd0);
        clear_counts();

        // 2-cycle SDA glitch is dropped
        bus_if.in_sda = 1'b0;
        cyc(2);
        bus_if.in_sda = 1'b1;
        cyc(10);
        check("glitch_sda_held", 32'(bus_if.out_sda), 32'd1);
        check("glitch_no_strobes", 32'(n_start + n_stop + n_rise + n_fall), 32'd0);

        // 3-cycle SDA low is accepted as START
        bus_if.in_sda = 1'b0;
        cyc(4);
        check("start_sda_hold_4", 32'(bus_if.out_sda), 32'd1);
        cyc();
        check("start_sda_fall_5", 32'(bus_if.out_sda), 32'd0);
        check("start_strobe", 32'(bus_if.out_start), 32'd1);
        check("start_busy_same_cycle", 32'(bus_if.out_bus_busy), 32'd1);
        cyc(5);

        // Full frame: 8 data bits + ACK(0), then STOP
        clear_counts();
        frame = 9'b1010_0101_0;
        for (int i = 8; i >= 0; i--) scl_clock(frame[i]);
        bus_if.in_sda = 1'b1;
        wait_strobe("frame_stop_wait", 1, 20, w);
        check("frame_busy_at_stop", 32'(bus_if.out_bus_busy), 32'd1);
        check("frame_rise_count", 32'(n_rise), 32'd9);
        check("frame_fall_count", 32'(n_fall), 32'd9);
        check("frame_no_extra_start", 32'(n_start), 32'd0);
        check("frame_busy_never_dropped", 32'(n_idle), 32'd0);
        cyc();
        check("frame_busy_after_stop", 32'(bus_if.out_bus_busy), 32'd0);
        cyc(10);

        // Repeated START
        bus_if.in_sda = 1'b0;
        wait_strobe("rs_first_start_wait", 0, 20, w);
        cyc(5);
        clear_counts();
        scl_clock(1'b1);
        scl_clock(1'b1);
        bus_if.in_sda = 1'b0;
        wait_strobe("rs_second_start_wait", 0, 20, w);
        check("rs_start_count", 32'(n_start), 32'd1);
        check("rs_rise_count", 32'(n_rise), 32'd2);
        check("rs_busy_never_dropped", 32'(n_idle), 32'd0);
        cyc(5);
        scl_clock(1'b0);
        bus_if.in_sda = 1'b1;
        cyc(12);
        check("rs_closed_by_stop", 32'(bus_if.out_bus_busy), 32'd0);

        // Simultaneous SCL/SDA change
        clear_counts();
        bus_if.in_scl = 1'b0;
        bus_if.in_sda = 1'b0;
        cyc(10);
        check("simul_fall_count", 32'(n_fall), 32'd1);
        check("simul_no_start", 32'(n_start), 32'd0);
        check("simul_stays_idle", 32'(bus_if.out_bus_busy), 32'd0);
        bus_if.in_scl = 1'b1;
        bus_if.in_sda = 1'b1;
        cyc(10);
        check("simul_rise_no_stop", 32'(n_stop), 32'd0);

        // Timeout: START then hold SCL low
        bus_if.in_sda = 1'b0;
        wait_strobe("tmo_start_wait", 0, 20, w);
        cyc(5);
        clear_counts();
        bus_if.in_scl = 1'b0;
        wait_strobe("tmo_fall_wait", 2, 20, w);
        wait_strobe("tmo_wait", 3, 200, w);
        check("tmo_latency", 32'(w), 32'd100);
        check("tmo_busy_cleared", 32'(bus_if.out_bus_busy), 32'd0);
        cyc(20);
        check("tmo_single_pulse", 32'(n_tmo), 32'd1);
        bus_if.in_scl = 1'b1;
        cyc(10);
        bus_if.in_sda = 1'b1;
        cyc(10);

        // Reset mid-frame
        bus_if.in_sda = 1'b0;
        wait_strobe("rst_start_wait", 0, 20, w);
        bus_if.in_scl = 1'b0;
        cyc(10);
        check("rst_busy_before", 32'(bus_if.out_bus_busy), 32'd1);
        clear_counts();
        in_rst_p = 1'b1;
        cyc();
        check("rst_busy_next_cycle", 32'(bus_if.out_bus_busy), 32'd0);
        cyc();
        in_rst_p = 1'b0;
        cyc(12);
        check("rst_no_stop", 32'(n_stop), 32'd0);
        check("rst_no_start", 32'(n_start), 32'd0);
        check("rst_stays_idle", 32'(bus_if.out_bus_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_bus_conditioner.md
Name: i2c_bus_conditioner

Overview:
Front-end stage that sits directly upstream of i2c_slave. It takes the raw SCL and SDA pad levels, synchronizes them into the in_clk domain, and deglitches them. It then emits filtered levels, single-cycle SCL edge strobes, START/STOP strobes and a bus-busy/timeout indication. i2c_slave consumes these strobes instead of sampling the pads directly, so all bus-event timing is decided in one place.

Parameters:
SYNC_STAGES, 2, flip-flops in each input synchronizer chain; legal range is 2 or more.
FILTER_CYCLES, 3, consecutive in_clk cycles a synchronized level must hold before the filtered output accepts it; legal range is 1 or more.
TIMEOUT_CYCLES, 2500000, in_clk cycles SCL may stay low while the bus is busy before a timeout fires; 0 disables the timeout.

Ports:
in_clk  input  1  system clock; all logic is on the rising edge.
in_rst_p  input  1  synchronous reset, active-high.
in_scl  input  1  raw SCL pad level, asynchronous.
in_sda  input  1  raw SDA pad level (input side of the bidirectional pad), asynchronous.
out_scl  output  1  filtered SCL level.
out_sda  output  1  filtered SDA level.
out_scl_rise  output  1  one-cycle strobe on a filtered SCL 0->1 transition.
out_scl_fall  output  1  one-cycle strobe on a filtered SCL 1->0 transition.
out_start  output  1  one-cycle strobe on a START or repeated START.
out_stop  output  1  one-cycle strobe on a STOP.
out_bus_busy  output  1  high from START until STOP or timeout.
out_timeout  output  1  one-cycle strobe when the SCL-low timeout expires.

Behaviour:
- Reset (in_rst_p high at a rising edge of in_clk):
  - Synchronizer flops set to 1.
  - out_scl and out_sda set to 1.
  - Filter counters, timeout counter and all strobes cleared to 0.
  - out_bus_busy cleared to 0; bus FSM returns to IDLE.
  - A reset mid-transfer abandons the transfer silently; no out_stop is issued.
- Synchronizer: a plain SYNC_STAGES-deep flop chain per line; no logic between stages.
- Filter (independent per line):
  - Counter increments while the synchronized level differs from the filtered level.
  - Counter clears to 0 in any cycle where the two levels are equal.
  - When the counter would reach FILTER_CYCLES, the filtered level toggles and the counter clears.
  - Pulses shorter than FILTER_CYCLES are therefore dropped.
  - Latency from pad change to filtered change is exactly SYNC_STAGES+FILTER_CYCLES cycles (5 at defaults).
- Edge strobes:
  - Registered and asserted in the same cycle the filtered level first shows its new value.
  - Exactly one cycle wide.
- START/STOP:
  - out_start: filtered SDA falls while filtered SCL is 1 and SCL does not change in that same cycle.
  - out_stop: filtered SDA rises under the same SCL conditions.
  - If SCL and SDA filtered levels change in the same cycle, only the SCL edge strobe fires; no START/STOP.
  - Both strobes are coincident with the SDA transition cycle.
- Bus FSM, two states:
  - IDLE -> BUSY on out_start.
  - BUSY -> BUSY on out_start (repeated START; out_start still pulses, busy stays high).
  - BUSY -> IDLE on out_stop, or on timeout.
  - out_stop in IDLE still pulses; state stays IDLE.
  - out_bus_busy = (state == BUSY).
- Timeout:
  - Counter is sized to hold TIMEOUT_CYCLES.
  - Counts while in BUSY with out_scl == 0; clears when out_scl == 1 or when not BUSY.
  - On reaching TIMEOUT_CYCLES: out_timeout pulses for one cycle, the FSM goes to IDLE, and the counter clears.
  - Counter saturates; it never wraps.
  - With TIMEOUT_CYCLES = 0, the counter and strobe are removed and out_timeout is tied to 0.
- Priority when events share a cycle: reset > timeout > START/STOP > hold.

Test Plan:
- Reset: assert in_rst_p for 2 cycles with pads at 0 -> every output at its reset value during reset. Release -> out_scl/out_sda fall to 0 exactly 5 cycles later, with out_scl_fall pulsing one cycle; no START strobe.
- Glitch rejection: SCL=1, SDA=1 idle; SDA low for 2 cycles, then high -> out_sda stays 1 and no strobes. SDA low for 3 cycles -> out_sda falls 5 cycles after the pad edge, and out_start pulses in that cycle.
- Full frame: START, 9 SCL clocks, STOP (SDA rises with SCL high) -> exactly 9 out_scl_rise and 9 out_scl_fall pulses; out_bus_busy high from the out_start cycle through the out_stop cycle, low the cycle after.
- Repeated START: START, 2 SCL clocks, SCL high, SDA 1->0 -> second out_start pulse; out_bus_busy never drops.
- Simultaneous change: SCL and SDA pads fall on the same cycle -> out_scl_fall only; out_start stays 0; FSM stays IDLE.
- Timeout (TIMEOUT_CYCLES=100): START, then hold SCL low -> out_timeout pulses once when the filtered-SCL-low count reaches 100, and out_bus_busy clears the same cycle. Separately, in_rst_p asserted mid-frame -> out_bus_busy 0 on the next cycle and no out_stop.
